// File: rtl/twiddle_rotator_seq_32b.sv
// rtl/twiddle_rotator_seq_32b.sv - radix-2 DIF stage sequencer with coarse quadrant twiddle rotation
module twiddle_rotator_seq_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cfg_stage,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_resid,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_stage;
  logic [5:0]  r_n;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_resid;
  logic [5:0]  r_out_index;
  logic        r_out_last;
  logic        r_out_valid;
  logic        r_done;

  logic        w_in_ready;
  logic        w_busy;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_start_ok;
  logic        w_last_out;
  logic [5:0]  w_half;
  logic [5:0]  w_mask;
  logic [5:0]  w_e;
  logic [31:0] w_rot;

  function automatic logic [15:0] sat_neg(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7FFF : (16'h0000 - x);
  endfunction

  // start is masked during the done cycle so a new frame begins one cycle later
  assign w_start_ok = start & (r_state == S_IDLE) & ~r_done;
  assign w_in_xfer  = in_valid & w_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_last_out = (r_state == S_DRAIN) & w_out_xfer & r_out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_in_xfer && (r_n == 6'd63)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_out) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_RUN) & (~r_out_valid | out_ready);
    w_busy     = (r_state != S_IDLE);
  end

  // exponent e = ((n & (half-1)) << s) mod 64 when the butterfly's upper half bit is set
  always_comb begin
    w_half = 6'd32 >> r_stage;
    w_mask = w_half - 6'd1;
    w_e    = ((r_n & w_half) != 6'd0) ? ((r_n & w_mask) << r_stage) : 6'd0;
  end

  always_comb begin
    case (w_e[5:4])
      2'd0:    w_rot = in_data;
      2'd1:    w_rot = {in_data[15:0], sat_neg(in_data[31:16])};
      2'd2:    w_rot = {sat_neg(in_data[31:16]), sat_neg(in_data[15:0])};
      default: w_rot = {sat_neg(in_data[15:0]), in_data[31:16]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage     <= 3'd0;
      r_n         <= 6'd0;
      r_out_data  <= 32'd0;
      r_out_resid <= 4'd0;
      r_out_index <= 6'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_out;
      if (w_start_ok) begin
        r_stage <= (cfg_stage > 3'd5) ? 3'd5 : cfg_stage;
        r_n     <= 6'd0;
      end
      if (w_in_xfer) begin
        r_n         <= r_n + 6'd1;
        r_out_data  <= w_rot;
        r_out_resid <= w_e[3:0];
        r_out_index <= r_n;
        r_out_last  <= (r_n == 6'd63);
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign done      = r_done;
  assign out_data  = r_out_data;
  assign out_resid = r_out_resid;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule

// File: doc/twiddle_rotator_seq_32b.md
# twiddle_rotator_seq_32b

Frame sequencer for one radix-2 decimation-in-frequency stage of the 64-point FFT. It accepts a stream of 64 packed complex samples and tracks each sample's index. From the stage number it computes the twiddle exponent for each sample. The coarse quadrant part of the twiddle (1, −j, −1, +j) is applied in-block with a one-cycle registered swap/negate. The residual 4-bit fine exponent is passed downstream to the general twiddle multiplier, alongside the rotated sample.

## Interface
Parameters: none (the stage is runtime configuration).

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame; honoured only in IDLE
- cfg_stage  in  3  stage 0..5; sampled on accepted start; values 6/7 treated as 5
- in_data  in  32  {real[31:16], imag[15:0]}, two's complement Q1.15
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- out_data  out  32  rotated sample, same packing
- out_resid  out  4  fine exponent e[3:0] for downstream multiplier
- out_index  out  6  sample index n of out_data
- out_last  out  1  high with the sample of index 63
- out_valid  out  1  output register holds a sample
- out_ready  in  1  downstream accepts the sample
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the frame's last sample is accepted downstream

## Operation
- **States:**
  - IDLE: waits for start. On start, latches the stage (s), clears n to 0, goes to RUN.
  - RUN: each input transfer (in_valid & in_ready) loads the output register and increments n. The transfer with n=63 moves to DRAIN.
  - DRAIN: waits for the output transfer of index 63. Then pulses done and returns to IDLE.
- **start:** ignored in RUN and DRAIN. It does not restart the frame.
- **Exponent:** half = 32 >> s. If (n & half) ≠ 0, then e = ((n & (half−1)) << s) mod 64. Otherwise e = 0. Quadrant q = e[5:4] and resid = e[3:0].
- **Rotation, with input (a = real, b = imag):**
  - q=0 → (a, b)
  - q=1 → (b, −a), i.e. multiply by −j
  - q=2 → (−a, −b)
  - q=3 → (−b, a)
- **Negation:** 16-bit two's complement, saturating: −0x8000 = 0x7FFF. No other arithmetic. Width is preserved.
- **out_index, out_last, out_resid:** registered together with out_data.

## Timing
- **Reset:** rst forces IDLE and n=0. All outputs go to 0: in_ready, out_valid, out_data, out_resid, out_index, out_last, busy, done. rst has priority over every other input, including mid-frame. A partial frame is discarded with no done.
- **in_ready:** (state==RUN) & (!out_valid | out_ready). It is combinational from state and output-register occupancy.
- **Latency:** 1 cycle. A sample transferred in cycle t appears with out_valid=1 in cycle t+1.
- **Throughput:** 1 sample/cycle when out_ready is held high.
- **Output register:** holds data and sideband stable while out_valid & !out_ready. out_valid drops the cycle after the transfer if no new input arrived.
- **Simultaneous transfers:** output transfer and input transfer in the same cycle reload the register with no bubble.
- **done:** asserted in the cycle after the index-63 output transfer. busy falls in that same cycle. A start in that same cycle is ignored. start is accepted from the next cycle onward.
- **Input valid outside RUN:** in_valid outside RUN is ignored, and no data is consumed.

## Test plan
- **Reset check:** assert rst for 2 cycles, with start and in_valid high during the reset. Required response: all outputs 0, state IDLE. After release, with start=0, in_ready stays 0.
- **Stage 0, streamed frame:** cfg_stage=0, 64 back-to-back samples, out_ready=1.
  - n=48, in 0x1234_5678 → out 0x5678_EDCC, resid 0, 1 cycle later.
  - n=5 → pass-through, resid 0.
  - n=40 → q=0, resid 8.
  - out_last only at index 63. done 1 cycle after the last output transfer.
- **Saturation:** stage 0, n=48, in 0x8000_0001 → out 0x0001_7FFF.
- **Stage 1:**
  - n=24 → e=16, q=1 (−j).
  - n=28 → e=24, q=1, resid 8.
  - n=8 → pass-through.
- **Stage 5:** every odd n → e=0, so all samples pass through unchanged with resid 0.
- **Backpressure and control:**
  - out_ready low 3 cycles mid-frame → out_data and out_index held, in_ready=0, no sample lost or duplicated.
  - start pulse in RUN → no effect on n.
  - rst at n=30 → back to IDLE with outputs 0. A new frame then starts at index 0.
